// File: rtl/theremin_cal_pkg.sv
// Shared types for the theremin frequency calibration sequencer.
// Holds the FSM state encoding and the iteration-counter width.
package theremin_cal_pkg;

    localparam int ITER_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        EVAL,
        STEP,
        SETTLE,
        DONE
    } cal_state_e;

endpackage

// File: rtl/freq_gate_counter.sv
// Synchronises an async square wave, detects rising edges and counts them over a
// GATE_CYCLES window; the count saturates and holds until clr.
module freq_gate_counter #(
    parameter int CNT_W       = 24,
    parameter int GATE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             gate_en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             window_done
);

    localparam int GATE_W = $clog2(GATE_CYCLES + 1);

    // [0],[1] form the synchroniser, [2] is the previous synchronised sample
    logic [2:0]        sync_q;
    logic [GATE_W-1:0] gate_q;
    logic [CNT_W-1:0]  count_q;
    logic              rise;

    assign rise        = sync_q[1] & ~sync_q[2];
    assign window_done = gate_en && (gate_q == GATE_W'(GATE_CYCLES - 1));
    assign count       = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            gate_q  <= '0;
            count_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
            if (clr) begin
                gate_q  <= '0;
                count_q <= '0;
            end else if (gate_en) begin
                gate_q <= window_done ? '0 : gate_q + 1'b1;
                if (rise && (count_q != '1)) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/theremin_freq_cal_ctrl.sv
// Closed-loop pitch-oscillator calibration: measure, compare with target, step up/down,
// settle, repeat until within tolerance or the iteration budget is spent.
module theremin_freq_cal_ctrl
    import theremin_cal_pkg::*;
#(
    parameter int CNT_W         = 24,
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 5000,
    parameter int MAX_ITER      = 255,
    parameter int TOL_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              square_freq,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  target_cnt,
    input  logic [TOL_W-1:0]  tol,
    output logic              busy,
    output logic              done,
    output logic              locked,
    output logic              fail,
    output logic              step_up,
    output logic              step_down,
    output logic [CNT_W-1:0]  meas_cnt,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int CMP_W    = (CNT_W + 1 > TOL_W) ? CNT_W + 1 : TOL_W;

    cal_state_e          state_q;
    logic [CNT_W-1:0]    tgt_q, meas_q;
    logic [TOL_W-1:0]    tol_q;
    logic [ITER_W-1:0]   iter_q;
    logic [SETTLE_W-1:0] settle_q;
    logic                busy_q, done_q, locked_q, fail_q, up_q, dn_q;

    logic [CNT_W-1:0] cnt;
    logic             window_done;
    logic [CNT_W:0]   diff, abs_diff;
    logic             within_tol;

    freq_gate_counter #(
        .CNT_W       (CNT_W),
        .GATE_CYCLES (GATE_CYCLES)
    ) u_gate (
        .clk         (clk),
        .reset       (reset),
        .clr         ((state_q == IDLE) || (state_q == SETTLE)),
        .gate_en     (state_q == MEASURE),
        .sig_in      (square_freq),
        .count       (cnt),
        .window_done (window_done)
    );

    // Zero-extended subtraction gives a CNT_W+1-bit two's-complement difference
    assign diff       = {1'b0, cnt} - {1'b0, tgt_q};
    assign abs_diff   = diff[CNT_W] ? (~diff + 1'b1) : diff;
    assign within_tol = CMP_W'(abs_diff) <= CMP_W'(tol_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            tol_q    <= '0;
            meas_q   <= '0;
            iter_q   <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                settle_q <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start && !abort) begin
                        tgt_q    <= target_cnt;
                        tol_q    <= tol;
                        iter_q   <= '0;
                        locked_q <= 1'b0;
                        fail_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= MEASURE;
                    end
                    MEASURE: if (window_done) state_q <= EVAL;
                    EVAL: begin
                        meas_q <= cnt;
                        if (within_tol) begin
                            locked_q <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else if (iter_q == ITER_W'(MAX_ITER)) begin
                            fail_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dn_q    <= (cnt > tgt_q);
                            up_q    <= !(cnt > tgt_q);
                            iter_q  <= iter_q + 1'b1;
                            state_q <= STEP;
                        end
                    end
                    STEP: begin
                        settle_q <= '0;
                        state_q  <= SETTLE;
                    end
                    SETTLE: if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        settle_q <= '0;
                        state_q  <= MEASURE;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign locked    = locked_q;
    assign fail      = fail_q;
    assign step_up   = up_q;
    assign step_down = dn_q;
    assign meas_cnt  = meas_q;
    assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_theremin_freq_cal_ctrl.sv
// Directed bench for the calibration sequencer: two instances (8-bit wide budget 255,
// 4-bit wide budget 3) driven by a model oscillator that slows on each step_down.
module tb_theremin_freq_cal_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, abort_a = 1'b0, sq_a = 1'b0;
    logic [7:0] tgt_a = '0, tol_a = '0;
    logic       busy_a, done_a, locked_a, fail_a, up_a, dn_a;
    logic [7:0] meas_a, iter_a;

    logic       start_b = 1'b0, abort_b = 1'b0, sq_b = 1'b0;
    logic [3:0] tgt_b = '0, tol_b = '0;
    logic       busy_b, done_b, locked_b, fail_b, up_b, dn_b;
    logic [3:0] meas_b;
    logic [7:0] iter_b;

    theremin_freq_cal_ctrl #(
        .CNT_W(8), .GATE_CYCLES(100), .SETTLE_CYCLES(20), .MAX_ITER(255), .TOL_W(8)
    ) dut_a (
        .clk(clk), .reset(reset), .square_freq(sq_a), .start(start_a), .abort(abort_a),
        .target_cnt(tgt_a), .tol(tol_a), .busy(busy_a), .done(done_a), .locked(locked_a),
        .fail(fail_a), .step_up(up_a), .step_down(dn_a), .meas_cnt(meas_a), .iter_cnt(iter_a)
    );

    theremin_freq_cal_ctrl #(
        .CNT_W(4), .GATE_CYCLES(100), .SETTLE_CYCLES(20), .MAX_ITER(3), .TOL_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .square_freq(sq_b), .start(start_b), .abort(abort_b),
        .target_cnt(tgt_b), .tol(tol_b), .busy(busy_b), .done(done_b), .locked(locked_b),
        .fail(fail_b), .step_up(up_b), .step_down(dn_b), .meas_cnt(meas_b), .iter_cnt(iter_b)
    );

    int pass_cnt = 0;
    int total    = 0;

    // Oscillator model (0 flat, 1 periodic, 2 toggle each clk) and pulse monitors
    int mode_a = 0, mode_b = 0, per_a = 10, ph_a = 0;
    int n_done_a = 0, n_up_a = 0, n_dn_a = 0, n_both = 0;
    int n_done_b = 0, n_up_b = 0, n_dn_b = 0;

    always @(negedge clk) begin
        if (mode_a == 1) begin
            ph_a = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
            sq_a = (ph_a < per_a / 2);
        end else begin
            sq_a = 1'b0;
        end
        if (mode_b == 2) sq_b = ~sq_b;
        else sq_b = 1'b0;
        if (done_a) n_done_a++;
        if (up_a) n_up_a++;
        if (dn_a) begin n_dn_a++; per_a++; end
        if ((up_a && dn_a) || (up_b && dn_b)) n_both++;
        if (done_b) n_done_b++;
        if (up_b) n_up_b++;
        if (dn_b) n_dn_b++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle_b(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy_b) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({busy_a, done_a, locked_a, fail_a, up_a, dn_a} !== 6'b0)
            $display("FAIL reset_flags_a: got %b want 000000", {busy_a, done_a, locked_a, fail_a, up_a, dn_a});
        else pass_cnt++;
        total++; if (meas_a !== 8'd0 || iter_a !== 8'd0)
            $display("FAIL reset_cnt_a: meas %0d iter %0d want 0 0", meas_a, iter_a);
        else pass_cnt++;
        total++; if ({busy_b, done_b, locked_b, fail_b, up_b, dn_b} !== 6'b0 || meas_b !== 4'd0)
            $display("FAIL reset_b: flags %b meas %0d want 0", {busy_b, done_b, locked_b, fail_b, up_b, dn_b}, meas_b);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_immediate_lock();
        int d0, u0, n0;
        bit ok;
        mode_a = 1; per_a = 10; tgt_a = 8'd10; tol_a = 8'd1;
        repeat (20) @(negedge clk);
        d0 = n_done_a; u0 = n_up_a; n0 = n_dn_a;
        pulse_start_a();
        tgt_a = 8'd3; tol_a = 8'd0;
        wait_idle_a(400, ok);
        total++; if (!ok) $display("FAIL lock_timeout: busy still %b want 0", busy_a); else pass_cnt++;
        total++; if (meas_a !== 8'd10) $display("FAIL lock_meas: got %0d want 10", meas_a); else pass_cnt++;
        total++; if (locked_a !== 1'b1 || fail_a !== 1'b0)
            $display("FAIL lock_status: locked %b fail %b want 1 0", locked_a, fail_a);
        else pass_cnt++;
        total++; if (iter_a !== 8'd0) $display("FAIL lock_iter: got %0d want 0", iter_a); else pass_cnt++;
        total++; if (n_done_a - d0 !== 1) $display("FAIL lock_done: got %0d pulses want 1", n_done_a - d0); else pass_cnt++;
        total++; if ((n_up_a - u0) + (n_dn_a - n0) !== 0)
            $display("FAIL lock_steps: got %0d pulses want 0", (n_up_a - u0) + (n_dn_a - n0));
        else pass_cnt++;
    endtask

    task automatic test_step_down_track();
        int d0, u0, n0;
        bit ok;
        per_a = 5; tgt_a = 8'd10; tol_a = 8'd0;
        repeat (20) @(negedge clk);
        d0 = n_done_a; u0 = n_up_a; n0 = n_dn_a;
        pulse_start_a();
        wait_idle_a(2000, ok);
        total++; if (!ok) $display("FAIL track_timeout: busy still %b want 0", busy_a); else pass_cnt++;
        total++; if (n_dn_a - n0 !== 5) $display("FAIL track_down: got %0d want 5", n_dn_a - n0); else pass_cnt++;
        total++; if (n_up_a - u0 !== 0) $display("FAIL track_up: got %0d want 0", n_up_a - u0); else pass_cnt++;
        total++; if (iter_a !== 8'd5) $display("FAIL track_iter: got %0d want 5", iter_a); else pass_cnt++;
        total++; if (locked_a !== 1'b1 || meas_a !== 8'd10)
            $display("FAIL track_lock: locked %b meas %0d want 1 10", locked_a, meas_a);
        else pass_cnt++;
        total++; if (per_a !== 10) $display("FAIL track_period: got %0d want 10", per_a); else pass_cnt++;
        total++; if (n_done_a - d0 !== 1) $display("FAIL track_done: got %0d want 1", n_done_a - d0); else pass_cnt++;
    endtask

    task automatic test_fail_budget();
        int d0, u0, n0;
        bit ok;
        mode_b = 0; tgt_b = 4'd10; tol_b = 4'd0;
        repeat (5) @(negedge clk);
        d0 = n_done_b; u0 = n_up_b; n0 = n_dn_b;
        pulse_start_b();
        wait_idle_b(1000, ok);
        total++; if (!ok) $display("FAIL budget_timeout: busy still %b want 0", busy_b); else pass_cnt++;
        total++; if (meas_b !== 4'd0) $display("FAIL budget_meas: got %0d want 0", meas_b); else pass_cnt++;
        total++; if (n_up_b - u0 !== 3 || n_dn_b - n0 !== 0)
            $display("FAIL budget_steps: up %0d down %0d want 3 0", n_up_b - u0, n_dn_b - n0);
        else pass_cnt++;
        total++; if (fail_b !== 1'b1 || locked_b !== 1'b0)
            $display("FAIL budget_status: fail %b locked %b want 1 0", fail_b, locked_b);
        else pass_cnt++;
        total++; if (iter_b !== 8'd3) $display("FAIL budget_iter: got %0d want 3", iter_b); else pass_cnt++;
        total++; if (n_done_b - d0 !== 1) $display("FAIL budget_done: got %0d want 1", n_done_b - d0); else pass_cnt++;
    endtask

    task automatic test_saturate();
        bit ok;
        mode_b = 2; tgt_b = 4'd10; tol_b = 4'd7;
        repeat (5) @(negedge clk);
        pulse_start_b();
        wait_idle_b(400, ok);
        total++; if (!ok) $display("FAIL sat_timeout: busy still %b want 0", busy_b); else pass_cnt++;
        total++; if (meas_b !== 4'd15) $display("FAIL sat_meas: got %0d want 15", meas_b); else pass_cnt++;
        total++; if (locked_b !== 1'b1 || fail_b !== 1'b0 || iter_b !== 8'd0)
            $display("FAIL sat_status: locked %b fail %b iter %0d want 1 0 0", locked_b, fail_b, iter_b);
        else pass_cnt++;
        mode_b = 0;
    endtask

    task automatic test_abort();
        int d0, n0, cyc;
        bit ok, seen;
        mode_a = 1; per_a = 5; tgt_a = 8'd10; tol_a = 8'd0;
        repeat (20) @(negedge clk);
        d0 = n_done_a; n0 = n_dn_a;
        pulse_start_a();
        repeat (50) @(negedge clk);
        pulse_start_a();
        cyc = 52; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (dn_a) begin seen = 1'b1; break; end
        end
        total++; if (!seen || cyc < 95 || cyc > 110)
            $display("FAIL busy_start_ignored: first step at cycle %0d seen %b want ~101", cyc, seen);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk) abort_a = 1'b0;
        total++; if (busy_a !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy_a); else pass_cnt++;
        total++; if (locked_a !== 1'b0 || fail_a !== 1'b0 || n_done_a - d0 !== 0)
            $display("FAIL abort_status: locked %b fail %b done %0d want 0 0 0", locked_a, fail_a, n_done_a - d0);
        else pass_cnt++;
        total++; if (meas_a !== 8'd20 || iter_a !== 8'd1)
            $display("FAIL abort_hold: meas %0d iter %0d want 20 1", meas_a, iter_a);
        else pass_cnt++;
        @(negedge clk) begin start_a = 1'b1; abort_a = 1'b1; end
        @(negedge clk) begin start_a = 1'b0; abort_a = 1'b0; end
        total++; if (busy_a !== 1'b0) $display("FAIL abort_wins: busy %b want 0", busy_a); else pass_cnt++;
        pulse_start_a();
        total++; if (busy_a !== 1'b1 || iter_a !== 8'd0)
            $display("FAIL restart: busy %b iter %0d want 1 0", busy_a, iter_a);
        else pass_cnt++;
        wait_idle_a(3000, ok);
        total++; if (!ok || locked_a !== 1'b1 || iter_a !== 8'd4 || n_dn_a - n0 !== 5)
            $display("FAIL restart_track: ok %b locked %b iter %0d downs %0d want 1 1 4 5", ok, locked_a, iter_a, n_dn_a - n0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int d0;
        bit ok;
        per_a = 10; tgt_a = 8'd10; tol_a = 8'd1;
        repeat (20) @(negedge clk);
        pulse_start_a();
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if ({busy_a, done_a, locked_a, fail_a, up_a, dn_a} !== 6'b0 || meas_a !== 8'd0 || iter_a !== 8'd0)
            $display("FAIL midreset_outputs: flags %b meas %0d iter %0d want 0", {busy_a, done_a, locked_a, fail_a, up_a, dn_a}, meas_a, iter_a);
        else pass_cnt++;
        reset = 1'b0;
        d0 = n_done_a;
        repeat (250) @(negedge clk);
        total++; if (busy_a !== 1'b0 || n_done_a - d0 !== 0 || meas_a !== 8'd0)
            $display("FAIL midreset_idle: busy %b done %0d meas %0d want 0 0 0", busy_a, n_done_a - d0, meas_a);
        else pass_cnt++;
        pulse_start_a();
        wait_idle_a(400, ok);
        total++; if (!ok || locked_a !== 1'b1 || meas_a !== 8'd10)
            $display("FAIL midreset_resume: ok %b locked %b meas %0d want 1 1 10", ok, locked_a, meas_a);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_immediate_lock();
        test_step_down_track();
        test_fail_budget();
        test_saturate();
        test_abort();
        test_reset_mid();
        total++; if (n_both !== 0) $display("FAIL step_exclusive: both pulses %0d times want 0", n_both);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
